// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the five-stage MIPS core.
// Carries one DATA_W payload with a valid/ready handshake. It supports a synchronous
// flush-to-bubble and a saturating stall counter.
// Optional feature macro: PIPE_SKID_EN.
//   Defined: EMPTY/FULL/SKID machine with a one-entry skid buffer and a registered in_ready.
//   Undefined: EMPTY/FULL machine with in_ready = !out_valid || out_ready.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 160,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stateT;

    stateT             r_state;
    stateT             w_nextState;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_nextMain;
    logic [CNT_W-1:0]  r_stallCnt;
    logic              w_stallInc;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_nextSkid;
    logic              r_inReady;
`endif

    // The output side is driven straight from registers, so there is no path from in_data.
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign stall_cnt = r_stallCnt;

`ifdef PIPE_SKID_EN
    assign in_ready = r_inReady;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    // Next-state and next-payload selection; flush overrides every other transition.
    always_comb begin
        w_nextState = r_state;
        w_nextMain  = r_main;
`ifdef PIPE_SKID_EN
        w_nextSkid  = r_skid;
`endif
        if (flush) begin
            w_nextState = ST_EMPTY;
            w_nextMain  = NOP_VALUE;
`ifdef PIPE_SKID_EN
            w_nextSkid  = NOP_VALUE;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_nextMain  = in_data;
                        w_nextState = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            w_nextMain = in_data;
                        end else begin
                            w_nextMain  = NOP_VALUE;
                            w_nextState = ST_EMPTY;
                        end
                    end
`ifdef PIPE_SKID_EN
                    else if (in_valid) begin
                        w_nextSkid  = in_data;
                        w_nextState = ST_SKID;
                    end
`endif
                end
`ifdef PIPE_SKID_EN
                ST_SKID: begin
                    if (out_ready) begin
                        w_nextMain  = r_skid;
                        w_nextSkid  = NOP_VALUE;
                        w_nextState = ST_FULL;
                    end
                end
`endif
                default: begin
                    w_nextState = ST_EMPTY;
                    w_nextMain  = NOP_VALUE;
                end
            endcase
        end
    end

    // State and payload registers; reset drops all held entries immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
            r_main  <= NOP_VALUE;
        end else begin
            r_state <= w_nextState;
            r_main  <= w_nextMain;
        end
    end

`ifdef PIPE_SKID_EN
    // Skid entry and registered upstream ready, low exactly while the skid entry is occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_skid    <= NOP_VALUE;
            r_inReady <= 1'b1;
        end else begin
            r_skid    <= w_nextSkid;
            r_inReady <= (w_nextState != ST_SKID);
        end
    end
`endif

    // A stall cycle is a live output refused downstream; flush cycles do not count.
    assign w_stallInc = out_valid && !out_ready && !flush;

    // Saturating stall counter; a clear request wins over an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stallCnt <= '0;
        end else if (stall_clr) begin
            r_stallCnt <= '0;
        end else if (w_stallInc && !(&r_stallCnt)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Builds with or without PIPE_SKID_EN; expectations that differ are selected by the same macro.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_clr;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (64'h0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive handshake inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // Advance one rising edge and sample shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts a failure and reports it.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks valid and payload together.
    task automatic checkOut(input string tag, input logic expValid, input logic [DATA_W-1:0] expData);
        checkOutput({tag, "_valid"}, {63'd0, out_valid}, {63'd0, expValid});
        checkOutput({tag, "_data"}, out_data, expData);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        checkOut("reset", 1'b0, 64'h0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_cnt", {60'd0, stall_cnt}, 64'd0);
        #9;
        reset_n = 1'b1;

        $display("[TB] streaming");
        applyStimulus(1'b1, 64'd1, 1'b1);
        checkOutput("stream_rdy1", {63'd0, in_ready}, 64'd1);
        tick();
        checkOut("stream1", 1'b1, 64'd1);
        applyStimulus(1'b1, 64'd2, 1'b1);
        checkOutput("stream_rdy2", {63'd0, in_ready}, 64'd1);
        tick();
        checkOut("stream2", 1'b1, 64'd2);
        applyStimulus(1'b1, 64'd3, 1'b1);
        checkOutput("stream_rdy3", {63'd0, in_ready}, 64'd1);
        tick();
        checkOut("stream3", 1'b1, 64'd3);
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        checkOut("stream_drain", 1'b0, 64'h0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 64'd10, 1'b1);
        tick();
        checkOut("bp_e1", 1'b1, 64'd10);
`ifdef PIPE_SKID_EN
        applyStimulus(1'b1, 64'd11, 1'b0);
        checkOutput("bp_rdy2", {63'd0, in_ready}, 64'd1);
        tick();
        checkOut("bp_e2", 1'b1, 64'd10);
        applyStimulus(1'b1, 64'd12, 1'b0);
        checkOutput("bp_rdy3", {63'd0, in_ready}, 64'd0);
        tick();
        checkOut("bp_e3", 1'b1, 64'd10);
        applyStimulus(1'b1, 64'd12, 1'b0);
        checkOutput("bp_rdy4", {63'd0, in_ready}, 64'd0);
        tick();
        checkOut("bp_e4", 1'b1, 64'd10);
        applyStimulus(1'b1, 64'd12, 1'b1);
        checkOutput("bp_rdy5", {63'd0, in_ready}, 64'd0);
        tick();
        checkOut("bp_e5", 1'b1, 64'd11);
`else
        applyStimulus(1'b1, 64'd11, 1'b0);
        checkOutput("bp_rdy2", {63'd0, in_ready}, 64'd0);
        tick();
        checkOut("bp_e2", 1'b1, 64'd10);
        applyStimulus(1'b1, 64'd11, 1'b0);
        checkOutput("bp_rdy3", {63'd0, in_ready}, 64'd0);
        tick();
        checkOut("bp_e3", 1'b1, 64'd10);
        applyStimulus(1'b1, 64'd11, 1'b0);
        checkOutput("bp_rdy4", {63'd0, in_ready}, 64'd0);
        tick();
        checkOut("bp_e4", 1'b1, 64'd10);
        applyStimulus(1'b1, 64'd11, 1'b1);
        checkOutput("bp_rdy5", {63'd0, in_ready}, 64'd1);
        tick();
        checkOut("bp_e5", 1'b1, 64'd11);
`endif
        applyStimulus(1'b1, 64'd12, 1'b1);
        checkOutput("bp_rdy6", {63'd0, in_ready}, 64'd1);
        tick();
        checkOut("bp_e6", 1'b1, 64'd12);
        applyStimulus(1'b1, 64'd13, 1'b1);
        tick();
        checkOut("bp_e7", 1'b1, 64'd13);
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        checkOut("bp_drain", 1'b0, 64'h0);
        checkOutput("bp_cnt", {60'd0, stall_cnt}, 64'd3);

        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checkOutput("clr_cnt", {60'd0, stall_cnt}, 64'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 64'hAAAA, 1'b1);
        tick();
        checkOut("fl_a", 1'b1, 64'hAAAA);
        applyStimulus(1'b1, 64'hBBBB, 1'b0);
        tick();
        checkOut("fl_b", 1'b1, 64'hAAAA);
        checkOutput("fl_cnt1", {60'd0, stall_cnt}, 64'd1);
        flush = 1'b1;
        applyStimulus(1'b1, 64'hCCCC, 1'b0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 64'd0, 1'b0);
        checkOut("fl_kill", 1'b0, 64'h0);
        checkOutput("fl_rdy", {63'd0, in_ready}, 64'd1);
        checkOutput("fl_cnt2", {60'd0, stall_cnt}, 64'd1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        checkOut("fl_idle1", 1'b0, 64'h0);
        tick();
        checkOut("fl_idle2", 1'b0, 64'h0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 64'h1234, 1'b1);
        tick();
        checkOut("ar_load", 1'b1, 64'h1234);
        applyStimulus(1'b0, 64'd0, 1'b0);
        tick();
        checkOutput("ar_cnt_pre", {60'd0, stall_cnt}, 64'd2);
        #1;
        reset_n = 1'b0;
        #1;
        checkOut("ar_now", 1'b0, 64'h0);
        checkOutput("ar_cnt", {60'd0, stall_cnt}, 64'd0);
        checkOutput("ar_rdy", {63'd0, in_ready}, 64'd1);
        #2;
        reset_n = 1'b1;

        $display("[TB] counter saturation");
        applyStimulus(1'b1, 64'h5555, 1'b1);
        tick();
        checkOut("sat_load", 1'b1, 64'h5555);
        applyStimulus(1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("sat_cnt14", {60'd0, stall_cnt}, 64'd14);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("sat_cnt20", {60'd0, stall_cnt}, 64'd15);
        checkOut("sat_hold", 1'b1, 64'h5555);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checkOutput("sat_clr", {60'd0, stall_cnt}, 64'd0);
        tick();
        checkOutput("sat_resume", {60'd0, stall_cnt}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
